// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner.
// Drives one row low at a time and samples the synchronized columns at the end
// of each row period. The four samples of a scan are merged into one result
// (no key, one key, or invalid). The result must repeat for DEBOUNCE_SCANS scans
// before it becomes the debounced state. A newly accepted key produces a
// one-cycle key_en strobe, and key_index is latched at the same time.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_index,
    output logic       key_en,
    output logic       key_held
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       DB_MAX   = 8'(DEBOUNCE_SCANS);

    // Number of active (low) columns in one sample: 0, 1, or 2 meaning "two or more".
    function automatic logic [1:0] col_hits(input logic [3:0] low);
        logic [2:0] n;
        n = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
        if (n == 3'd0) begin
            return 2'd0;
        end else if (n == 3'd1) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    // Position of the lowest active column. Only meaningful when exactly one column is active.
    function automatic logic [1:0] col_pos(input logic [3:0] low);
        logic [1:0] p;
        casez (low)
            4'b???1: p = 2'd0;
            4'b??10: p = 2'd1;
            4'b?100: p = 2'd2;
            4'b1000: p = 2'd3;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    logic [3:0]       col_meta_r, col_sync_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       row_r;
    logic [3:0]       row_out_r;
    logic [1:0]       acc_hits_r;
    logic [3:0]       acc_idx_r;
    logic             cand_key_r;
    logic [3:0]       cand_idx_r;
    logic [7:0]       count_r;
    logic             deb_key_r;
    logic [3:0]       deb_idx_r;
    logic             key_en_r, key_held_r;
    logic [3:0]       key_index_r;

    logic             row_last_s, scan_end_s;
    logic [1:0]       row_nxt_s;
    logic [3:0]       low_s;
    logic [1:0]       samp_hits_s, tot_hits_s;
    logic [3:0]       samp_idx_s, tot_idx_s;
    logic             res_key_s, match_s, accept_s, strobe_s;
    logic [3:0]       res_idx_s;
    logic [7:0]       count_nxt_s;

    // Decode this cycle's sample and merge it with the hits already seen in the current scan.
    always_comb begin
        row_last_s  = (div_r == DIV_LAST);
        scan_end_s  = row_last_s && (row_r == 2'd3);
        row_nxt_s   = row_r + 2'd1;
        low_s       = ~col_sync_r;
        samp_hits_s = col_hits(low_s);
        samp_idx_s  = {row_r, col_pos(low_s)};
        if (samp_hits_s == 2'd0) begin
            tot_hits_s = acc_hits_r;
            tot_idx_s  = acc_idx_r;
        end else if ((samp_hits_s == 2'd1) && (acc_hits_r == 2'd0)) begin
            tot_hits_s = 2'd1;
            tot_idx_s  = samp_idx_s;
        end else begin
            tot_hits_s = 2'd2;
            tot_idx_s  = acc_idx_r;
        end
        // An invalid scan collapses to NONE, which is encoded with index 0.
        res_key_s = (tot_hits_s == 2'd1);
        if (res_key_s) begin
            res_idx_s = tot_idx_s;
        end else begin
            res_idx_s = 4'd0;
        end
        match_s = (res_key_s == cand_key_r) && (res_idx_s == cand_idx_r);
        if (!match_s) begin
            count_nxt_s = 8'd1;
        end else if (count_r < DB_MAX) begin
            count_nxt_s = count_r + 8'd1;
        end else begin
            count_nxt_s = count_r;
        end
        accept_s = scan_end_s && match_s && (count_r == (DB_MAX - 8'd1));
        strobe_s = accept_s && cand_key_r && (!deb_key_r || (deb_idx_r != cand_idx_r));
    end

    // Two-flop synchronizer for the asynchronous column inputs. Idle columns read high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_meta_r <= 4'b1111;
            col_sync_r <= 4'b1111;
        end else begin
            col_meta_r <= col_in;
            col_sync_r <= col_meta_r;
        end
    end

    // Row period divider and row counter. The row drive is registered together with the row.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_r     <= '0;
            row_r     <= 2'd0;
            row_out_r <= 4'b1110;
        end else if (row_last_s) begin
            div_r     <= '0;
            row_r     <= row_nxt_s;
            row_out_r <= ~(4'b0001 << row_nxt_s);
        end else begin
            div_r     <= div_r + DIV_W'(1);
            row_r     <= row_r;
            row_out_r <= row_out_r;
        end
    end

    // Per-scan hit accumulator. Updated on each row sample and cleared once the scan is evaluated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_hits_r <= 2'd0;
            acc_idx_r  <= 4'd0;
        end else if (scan_end_s) begin
            acc_hits_r <= 2'd0;
            acc_idx_r  <= 4'd0;
        end else if (row_last_s) begin
            acc_hits_r <= tot_hits_s;
            acc_idx_r  <= tot_idx_s;
        end else begin
            acc_hits_r <= acc_hits_r;
            acc_idx_r  <= acc_idx_r;
        end
    end

    // Debounce: candidate with a saturating stable count, promoted to the debounced state when the count fills.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cand_key_r <= 1'b0;
            cand_idx_r <= 4'd0;
            count_r    <= 8'd0;
            deb_key_r  <= 1'b0;
            deb_idx_r  <= 4'd0;
        end else if (scan_end_s) begin
            if (!match_s) begin
                cand_key_r <= res_key_s;
                cand_idx_r <= res_idx_s;
            end else begin
                cand_key_r <= cand_key_r;
                cand_idx_r <= cand_idx_r;
            end
            count_r <= count_nxt_s;
            if (accept_s) begin
                deb_key_r <= cand_key_r;
                deb_idx_r <= cand_idx_r;
            end else begin
                deb_key_r <= deb_key_r;
                deb_idx_r <= deb_idx_r;
            end
        end else begin
            cand_key_r <= cand_key_r;
            cand_idx_r <= cand_idx_r;
            count_r    <= count_r;
            deb_key_r  <= deb_key_r;
            deb_idx_r  <= deb_idx_r;
        end
    end

    // Registered outputs: strobe on a new key, latch its index, and follow the debounced key state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_en_r    <= 1'b0;
            key_index_r <= 4'd0;
            key_held_r  <= 1'b0;
        end else begin
            key_en_r <= strobe_s;
            if (strobe_s) begin
                key_index_r <= cand_idx_r;
            end else begin
                key_index_r <= key_index_r;
            end
            if (accept_s) begin
                key_held_r <= cand_key_r;
            end else begin
                key_held_r <= key_held_r;
            end
        end
    end

    assign row_out   = row_out_r;
    assign key_index = key_index_r;
    assign key_en    = key_en_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner. A switch matrix model converts a pressed-key
// mask into column levels. A scan-level reference model predicts every output
// on every cycle. Directed phases also check hand-computed literal values.
module tb_keypad_scanner;

    localparam int SD   = 4;
    localparam int DB   = 3;
    localparam int SCAN = 4 * SD;

    localparam logic [15:0] K0 = 16'h0001;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K6 = 16'h0040;
    localparam logic [15:0] K9 = 16'h0200;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_index;
    logic        key_en;
    logic        key_held;
    logic [15:0] mask;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int         tick    = 0;
    bit         m_valid = 1'b0;
    int         m_cyc, m_prev, m_run, m_deb;
    logic       e_en, e_held;
    logic [3:0] e_idx;

    // observation counters
    int en_count = 0;
    int en_tick  = 0;
    int held_low = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_index (key_index),
        .key_en    (key_en),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // switch matrix: a pressed key pulls its column low while its row is driven low
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (row_out[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (mask[r*4+c]) col_in[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scan outcome from the set of pressed keys: the index if exactly one key is down, else -1 (none).
    function automatic int scan_res(input logic [15:0] m);
        int n;
        int idx;
        n = 0;
        idx = -1;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    // Reference model. A result is accepted when it has been seen DB scans in a row.
    initial begin
        int r;
        forever begin
            @(posedge clk);
            tick++;
            if (!rst) begin
                m_valid = 1'b1;
                m_cyc   = 0;
                m_prev  = -2;
                m_run   = 0;
                m_deb   = -1;
                e_en    = 1'b0;
                e_idx   = 4'd0;
                e_held  = 1'b0;
            end else begin
                e_en = 1'b0;
                if (m_cyc % SCAN == SCAN - 1) begin
                    r = scan_res(mask);
                    if (r == m_prev) begin
                        m_run++;
                    end else begin
                        m_prev = r;
                        m_run  = 1;
                    end
                    if (m_run == DB) begin
                        if (r >= 0 && r != m_deb) begin
                            e_en  = 1'b1;
                            e_idx = 4'(r);
                        end
                        m_deb  = r;
                        e_held = (r >= 0);
                    end
                end
                m_cyc++;
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    initial begin
        logic [3:0] one;
        logic [3:0] exp_row;
        one = 4'b0001;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp_row = ~(one << ((m_cyc / SD) % 4));
                chk("row_out", row_out, exp_row);
                chk("key_en", {3'b000, key_en}, {3'b000, e_en});
                chk("key_index", key_index, e_idx);
                chk("key_held", {3'b000, key_held}, {3'b000, e_held});
            end
            if (key_en === 1'b1) begin
                en_count++;
                en_tick = tick;
            end
            if (key_held !== 1'b1) held_low++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_scans(input int n, input logic [15:0] m);
        mask = m;
        step(n * SCAN);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_row"}, row_out, 4'b1110);
        chk({tag, "_en"}, {3'b000, key_en}, 4'd0);
        chk({tag, "_idx"}, key_index, 4'd0);
        chk({tag, "_held"}, {3'b000, key_held}, 4'd0);
    endtask

    // Watchdog in case the run fails to finish.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        logic [3:0] row_lit [4];
        int c0;
        int p0;
        row_lit[0] = 4'b1110;
        row_lit[1] = 4'b1101;
        row_lit[2] = 4'b1011;
        row_lit[3] = 4'b0111;
        rst  = 1'b0;
        mask = 16'h0000;
        step(3);
        chk_reset_outputs("reset");
        rst = 1'b1;

        // idle: row sequence, no strobe, nothing held
        for (int k = 0; k < SCAN; k++) begin
            if (k % SD == 0) chk("row_seq", row_out, row_lit[k/SD]);
            step(1);
        end
        run_scans(3, 16'h0000);
        chk_int("idle_strobes", en_count, 0);
        chk("idle_held", {3'b000, key_held}, 4'd0);

        // key 6 steady for 5 scans
        c0 = en_count;
        p0 = tick;
        run_scans(5, K6);
        chk_int("k6_strobes", en_count - c0, 1);
        chk_int("k6_latency", en_tick - p0, 3 * SCAN);
        chk("k6_idx", key_index, 4'd6);
        chk("k6_held", {3'b000, key_held}, 4'd1);
        c0 = en_count;
        run_scans(4, 16'h0000);
        chk_int("k6_rel_strobes", en_count - c0, 0);
        chk("k6_rel_held", {3'b000, key_held}, 4'd0);
        chk("k6_rel_idx", key_index, 4'd6);

        // bounce: toggling scans never debounce, then a stable press strobes once
        c0 = en_count;
        repeat (3) begin
            run_scans(1, K6);
            run_scans(1, 16'h0000);
        end
        chk_int("bounce_strobes", en_count - c0, 0);
        p0 = tick;
        run_scans(4, K6);
        chk_int("bounce_final_strobes", en_count - c0, 1);
        chk_int("bounce_latency", en_tick - p0, 3 * SCAN);
        run_scans(4, 16'h0000);

        // two keys together are invalid; releasing one leaves a valid key 0
        c0 = en_count;
        run_scans(4, K0 | K5);
        chk_int("dual_strobes", en_count - c0, 0);
        chk("dual_held", {3'b000, key_held}, 4'd0);
        p0 = tick;
        run_scans(4, K0);
        chk_int("k0_strobes", en_count - c0, 1);
        chk_int("k0_latency", en_tick - p0, 3 * SCAN);
        chk("k0_idx", key_index, 4'd0);
        chk("k0_held", {3'b000, key_held}, 4'd1);

        // rollover 0 -> 6 -> 9 with no release, long hold, then release
        c0 = en_count;
        run_scans(4, K6);
        chk_int("roll6_strobes", en_count - c0, 1);
        chk("roll6_idx", key_index, 4'd6);
        c0 = en_count;
        held_low = 0;
        run_scans(8, K9);
        chk_int("roll9_strobes", en_count - c0, 1);
        chk("roll9_idx", key_index, 4'd9);
        chk_int("roll9_held_drops", held_low, 0);
        c0 = en_count;
        run_scans(4, 16'h0000);
        chk_int("roll9_rel_strobes", en_count - c0, 0);
        chk("roll9_rel_held", {3'b000, key_held}, 4'd0);
        chk("roll9_rel_idx", key_index, 4'd9);

        // reset in the middle of debouncing key 6, key still held afterwards
        run_scans(2, K6);
        step(5);
        rst = 1'b0;
        step(1);
        chk_reset_outputs("midrst");
        step(1);
        rst = 1'b1;
        c0 = en_count;
        p0 = tick;
        run_scans(4, K6);
        chk_int("post_rst_strobes", en_count - c0, 1);
        chk_int("post_rst_latency", en_tick - p0, 3 * SCAN);
        chk("post_rst_idx", key_index, 4'd6);
        chk("post_rst_held", {3'b000, key_held}, 4'd1);
        run_scans(2, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
